ub_feed_sequencer: RTL and testbench
====================================

# ub_feed_sequencer

Read-side initiator for the unified buffer. It takes a tile-loop command and generates the per-cycle input and weight read addresses, plus first/last markers, that drive the buffer's two read ports. Between tiles it inserts drain gaps so the systolic array can flush partial sums. It reports completion with a done pulse.

## Interface
Parameters:
- ADDR_W, `ADDR_WIDTH: buffer address width.
- LEN_W, 8: width of the per-tile length field.
- TILE_W, 8: width of the tile-count field.
- DRAIN_CYCLES, 2: idle cycles inserted after every tile. 0 means no gap.

Ports:
- clk  in  1  clock; all logic is on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- input_base  in  ADDR_W  first input row of tile 0.
- weight_base  in  ADDR_W  first weight row of tile 0.
- input_stride  in  ADDR_W  input base increment per tile.
- weight_stride  in  ADDR_W  weight base increment per tile.
- length  in  LEN_W  rows per tile (L).
- num_tiles  in  TILE_W  tile count (T).
- stall  in  1  array backpressure; freezes sequencing.
- input_addr  out  ADDR_W  input read address.
- input_first, input_last  out  1  input markers.
- weight_addr  out  ADDR_W  weight read address.
- weight_first, weight_last  out  1  weight markers.
- feed_valid  out  1  the addresses are a real beat.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

## Operation
- Command latching: all command fields are latched when start is accepted. Later changes to them have no effect.
- Beat k of tile t (k = 0..L-1, t = 0..T-1):
  - input_addr = input_base + t*input_stride + k.
  - weight_addr = weight_base + t*weight_stride + k.
- Arithmetic: all address sums are modulo 2^ADDR_W, so wrap-around is silent. Implement with running tile-base registers plus a k counter, not a multiplier.
- Markers: *_first is high on k=0 and *_last is high on k=L-1. For L=1 both are high in the same beat. The input and weight markers are always identical.
- States:
  - IDLE: on start, go to FEED if L≠0 and T≠0; otherwise go to FINISH.
  - FEED: issues one beat per non-stalled cycle. After beat L-1, go to DRAIN if DRAIN_CYCLES>0, otherwise go to next-tile handling.
  - DRAIN: counts DRAIN_CYCLES non-stalled cycles with feed_valid=0.
  - Next-tile handling: if t<T-1, add the strides to the tile bases, clear k and return to FEED. Otherwise go to FINISH.
  - FINISH: pulses done for one cycle and returns to IDLE.
- Stall, in FEED or DRAIN:
  - Addresses hold their value and no counter advances.
  - feed_valid, first and last are driven 0, so a held address never re-issues a marker.
  - Stall in IDLE or FINISH has no effect.
- start outside IDLE is ignored. start in the same cycle as the done pulse is also ignored; it is accepted the next cycle.

## Timing
- Reset value of every output is 0, including addresses, markers, feed_valid, busy and done.
- Reset asserted mid-operation aborts to IDLE immediately. No done is produced.
- All outputs are registered.
- With start accepted on edge N:
  - beat 0 is on the outputs after edge N+1;
  - the buffer returns its data after edge N+2.
- Unstalled total: done is high for the cycle following the last drain cycle. The command occupies T·(L+DRAIN_CYCLES) beat/drain cycles, plus one start cycle and one FINISH cycle.
- busy is high from the cycle after start acceptance through the FINISH cycle inclusive.
- With L=0 or T=0, done is high in the cycle after start acceptance and feed_valid never rises.

## Structure
- Shared package ub_seq_pkg holds:
  - the state enum typedef (IDLE, FEED, DRAIN, FINISH);
  - a command struct typedef (bases, strides, length, num_tiles) used for the latched copy.
- No sub-module. Implement as one module with two inline address generators sharing a single k counter and tile counter.

## Test plan
- L=4, T=1, bases 0x10 and 0x40, DRAIN=2, no stall:
  - input addresses 0x10–0x13 and weight addresses 0x40–0x43;
  - first on 0x10/0x40, last on 0x13/0x43;
  - done 7 cycles after the start edge (4 beats, 2 drain, 1 FINISH).
- L=3, T=2, input_stride=8, weight_stride=0:
  - tile 1 inputs are 0x18–0x1A and weights repeat 0x40–0x42;
  - exactly two first/last pairs are issued, with a 2-cycle feed_valid=0 gap between tiles.
- Stall held 3 cycles on beat 1:
  - address 0x11 is held with feed_valid=0 and markers 0;
  - the beat sequence then resumes unchanged;
  - done is delayed by exactly 3 cycles.
- Wrap and L=1 boundaries:
  - input_base = 2^ADDR_W−2 with L=4 gives addresses …FE, …FF, 0x00, 0x01;
  - L=1 gives first and last high in the same beat.
- L=0 → done high in the cycle after start acceptance with no feed_valid. start pulsed while busy → ignored. rst_n low mid-FEED → all outputs 0 next cycle and no done.

Source files
------------

// File: rtl/ub_seq_pkg.sv
// Shared types for the unified-buffer read-side feed sequencer:
// FSM state encoding and the latched tile-loop command.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package ub_seq_pkg;

    localparam int UB_ADDR_W = `ADDR_WIDTH;
    localparam int UB_LEN_W  = 8;
    localparam int UB_TILE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [UB_ADDR_W-1:0] input_base;
        logic [UB_ADDR_W-1:0] weight_base;
        logic [UB_ADDR_W-1:0] input_stride;
        logic [UB_ADDR_W-1:0] weight_stride;
        logic [UB_LEN_W-1:0]  length;
        logic [UB_TILE_W-1:0] num_tiles;
    } seq_cmd_t;

endpackage

// File: rtl/ub_feed_sequencer.sv
// Unified-buffer read initiator: walks a tile loop, emitting input/weight read
// addresses with first/last markers and drain gaps between tiles.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module ub_feed_sequencer
    import ub_seq_pkg::*;
#(
    parameter int ADDR_W       = `ADDR_WIDTH,
    parameter int LEN_W        = 8,
    parameter int TILE_W       = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] input_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] input_stride,
    input  logic [ADDR_W-1:0] weight_stride,
    input  logic [LEN_W-1:0]  length,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    output logic [ADDR_W-1:0] input_addr,
    output logic              input_first,
    output logic              input_last,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              weight_first,
    output logic              weight_last,
    output logic              feed_valid,
    output logic              busy,
    output logic              done
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // The latched command copy is typed by the package, so widths must agree.
    if (ADDR_W != UB_ADDR_W || LEN_W != UB_LEN_W || TILE_W != UB_TILE_W) begin : g_width_check
        $error("ub_feed_sequencer: parameter widths differ from ub_seq_pkg");
    end

    seq_state_e        state_q, state_d;
    seq_cmd_t          cmd_q, cmd_d;
    logic [ADDR_W-1:0] in_off_q, in_off_d, wt_off_q, wt_off_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [ADDR_W-1:0] in_addr_d, wt_addr_d;
    logic              vld_d, first_d, last_d, busy_d, done_d;
    logic              beat_last, tile_last, adv_tile;

    assign beat_last = (k_q == cmd_q.length - LEN_W'(1));
    assign tile_last = (tile_q == cmd_q.num_tiles - TILE_W'(1));

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        in_off_d  = in_off_q;
        wt_off_d  = wt_off_q;
        k_d       = k_q;
        tile_d    = tile_q;
        drain_d   = drain_q;
        in_addr_d = input_addr;
        wt_addr_d = weight_addr;
        vld_d     = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
        adv_tile  = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a start there waits one cycle.
                if (start && !done) begin
                    cmd_d = '{input_base: input_base, weight_base: weight_base,
                              input_stride: input_stride, weight_stride: weight_stride,
                              length: length, num_tiles: num_tiles};
                    in_off_d = '0;
                    wt_off_d = '0;
                    k_d      = '0;
                    tile_d   = '0;
                    drain_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = (length != '0 && num_tiles != '0) ? FEED : FINISH;
                end
            end
            FEED: begin
                if (!stall) begin
                    in_addr_d = cmd_q.input_base + in_off_q + ADDR_W'(k_q);
                    wt_addr_d = cmd_q.weight_base + wt_off_q + ADDR_W'(k_q);
                    vld_d     = 1'b1;
                    first_d   = (k_q == '0);
                    last_d    = beat_last;
                    if (!beat_last) begin
                        k_d = k_q + LEN_W'(1);
                    end else if (DRAIN_CYCLES > 0) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        adv_tile = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_q == DW'(DRAIN_CYCLES - 1)) adv_tile = 1'b1;
                    else drain_d = drain_q + DW'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv_tile) begin
            if (tile_last) begin
                state_d = FINISH;
            end else begin
                tile_d   = tile_q + TILE_W'(1);
                in_off_d = in_off_q + cmd_q.input_stride;
                wt_off_d = wt_off_q + cmd_q.weight_stride;
                k_d      = '0;
                state_d  = FEED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            in_off_q     <= '0;
            wt_off_q     <= '0;
            k_q          <= '0;
            tile_q       <= '0;
            drain_q      <= '0;
            input_addr   <= '0;
            weight_addr  <= '0;
            input_first  <= 1'b0;
            input_last   <= 1'b0;
            weight_first <= 1'b0;
            weight_last  <= 1'b0;
            feed_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            in_off_q     <= in_off_d;
            wt_off_q     <= wt_off_d;
            k_q          <= k_d;
            tile_q       <= tile_d;
            drain_q      <= drain_d;
            input_addr   <= in_addr_d;
            weight_addr  <= wt_addr_d;
            input_first  <= first_d;
            input_last   <= last_d;
            weight_first <= first_d;
            weight_last  <= last_d;
            feed_valid   <= vld_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_ub_feed_sequencer.sv
// Scoreboard bench for ub_feed_sequencer: expected beats are queued per command
// from the tile-loop formula, a monitor pops them on every valid beat.
module tb_ub_feed_sequencer;

    localparam int AW = 16;
    localparam int LW = 8;
    localparam int TW = 8;
    localparam int DR = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stall;
    logic [AW-1:0] input_base, weight_base, input_stride, weight_stride;
    logic [LW-1:0] length;
    logic [TW-1:0] num_tiles;
    logic [AW-1:0] input_addr, weight_addr;
    logic          input_first, input_last, weight_first, weight_last;
    logic          feed_valid, busy, done;

    typedef struct packed {
        logic [AW-1:0] ia;
        logic [AW-1:0] wa;
        logic          f;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    ub_feed_sequencer #(
        .ADDR_W(AW), .LEN_W(LW), .TILE_W(TW), .DRAIN_CYCLES(DR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_base(input_base), .weight_base(weight_base),
        .input_stride(input_stride), .weight_stride(weight_stride),
        .length(length), .num_tiles(num_tiles), .stall(stall),
        .input_addr(input_addr), .input_first(input_first), .input_last(input_last),
        .weight_addr(weight_addr), .weight_first(weight_first), .weight_last(weight_last),
        .feed_valid(feed_valid), .busy(busy), .done(done)
    );

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: every valid beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (feed_valid) begin
                beat_t got, want;
                got = '{ia: input_addr, wa: weight_addr, f: input_first, l: input_last};
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b0, longint'(got), 0);
                end else begin
                    want = exp_q.pop_front();
                    check("beat", got == want && weight_first == want.f && weight_last == want.l,
                          longint'({got, weight_first, weight_last}),
                          longint'({want, want.f, want.l}));
                end
            end else begin
                check("markers_idle", {input_first, input_last, weight_first, weight_last} == 4'b0,
                      {input_first, input_last, weight_first, weight_last}, 0);
            end
        end
    end

    task automatic set_fields(input int ib, wb, is, ws, l, t);
        input_base    = AW'(ib);
        weight_base   = AW'(wb);
        input_stride  = AW'(is);
        weight_stride = AW'(ws);
        length        = LW'(l);
        num_tiles     = TW'(t);
    endtask

    task automatic do_abort();
        rst_n = 1'b0;
        #1;
        check("reset_async_clear",
              {input_addr, weight_addr, input_first, input_last, weight_first, weight_last,
               feed_valid, busy, done} == '0,
              {input_addr, weight_addr, feed_valid, busy, done}, 0);
        exp_q.delete();
        start = 1'b0;
        stall = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("no_done_in_reset", done == 1'b0 && feed_valid == 1'b0, {done, feed_valid}, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("idle_after_reset", busy == 1'b0 && done == 1'b0, {busy, done}, 0);
    endtask

    // Issue one command and follow it to done. Work units: each non-stalled cycle
    // in the tile loop consumes one of T*(L+DR); done follows the last unit.
    task automatic run_cmd(input int ib, wb, is, ws, l, t,
                           input int stall_pct, stall_at, stall_len, abort_at);
        logic [AW-1:0] pin, pwt;
        int  rem, used, stall_run;
        bit  s, got_done, armed;
        beat_t b;

        if (done === 1'b1) begin
            set_fields(ib, wb, is, ws, l, t);
            start = 1'b1;
            stall = 1'b0;
            @(posedge clk); @(negedge clk);
            check("start_in_done_ignored", busy == 1'b0 && done == 1'b0, {busy, done}, 0);
        end

        set_fields(ib, wb, is, ws, l, t);
        start = 1'b1;
        stall = 1'($urandom_range(0, 1));
        for (int tt = 0; tt < t; tt++) begin
            for (int kk = 0; kk < l; kk++) begin
                b.ia = AW'(ib + tt * is + kk);
                b.wa = AW'(wb + tt * ws + kk);
                b.f  = (kk == 0);
                b.l  = (kk == l - 1);
                exp_q.push_back(b);
            end
        end
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        set_fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        check("busy_after_start", busy == 1'b1, busy, 1);

        rem       = (l == 0 || t == 0) ? 0 : t * (l + DR);
        used      = 0;
        stall_run = 0;
        armed     = (stall_at >= 0);
        got_done  = 1'b0;
        pin       = input_addr;
        pwt       = weight_addr;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            if (abort_at >= 0 && used == abort_at) begin
                do_abort();
                return;
            end
            if (armed && used == stall_at) begin
                stall_run = stall_len;
                armed     = 1'b0;
            end
            s = (stall_run > 0) ? 1'b1 : ($urandom_range(0, 99) < stall_pct);
            if (stall_run > 0) stall_run--;
            stall = s;
            start = ($urandom_range(0, 7) == 0);
            @(posedge clk); @(negedge clk);
            if (rem == 0) begin
                check("done_timing", done == 1'b1, done, 1);
                check("busy_at_done", busy == 1'b1, busy, 1);
                check("all_beats_issued", exp_q.size() == 0, exp_q.size(), 0);
                got_done = 1'b1;
            end else begin
                check("done_early", done == 1'b0, done, 0);
                if (s) begin
                    check("stall_hold",
                          feed_valid == 1'b0 && input_addr == pin && weight_addr == pwt,
                          {feed_valid, input_addr, weight_addr}, {1'b0, pin, pwt});
                end else begin
                    rem--;
                    used++;
                end
            end
            pin = input_addr;
            pwt = weight_addr;
        end
        if (!got_done) check("done_timeout", 1'b0, 0, 1);
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {input_addr, weight_addr, input_first, input_last, weight_first, weight_last,
               feed_valid, busy, done} == '0,
              {input_addr, weight_addr, feed_valid, busy, done}, 0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        run_cmd('h10, 'h40, 0, 0, 4, 1, 0, -1, 0, -1);
        run_cmd('h10, 'h40, 8, 0, 3, 2, 0, -1, 0, -1);
        run_cmd('h10, 'h40, 0, 0, 4, 1, 0, 2, 3, -1);
        run_cmd('hFFFE, 'hFFFD, 0, 0, 4, 1, 0, -1, 0, -1);
        run_cmd('h200, 'h300, 'h10, 'h20, 1, 3, 0, -1, 0, -1);
        run_cmd('h50, 'h60, 1, 1, 0, 3, 0, -1, 0, -1);
        run_cmd('h50, 'h60, 1, 1, 5, 0, 0, -1, 0, -1);
        run_cmd('h100, 'h200, 4, 4, 8, 2, 0, -1, 0, 3);
        for (int i = 0; i < 12; i++) begin
            run_cmd($urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 6), $urandom_range(0, 3), 25, -1, 0, -1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_idle", busy == 1'b0 && feed_valid == 1'b0 && exp_q.size() == 0,
              {busy, feed_valid}, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
